// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential signed divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX,
      DONE
   } div_state_e;

   localparam int DIV_DW = 5;
   localparam int DIV_VW = 3;

   // Bit counter width; a 1-bit dividend still needs a 1-bit counter.
   function automatic int div_cnt_w(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract, keep or restore.
module div_step #(
   parameter int VW = 3
) (
   input  logic [VW:0]   prem_i,
   input  logic          bit_i,
   input  logic [VW-1:0] dvs_i,
   output logic [VW:0]   prem_o,
   output logic          q_o
);

   logic [VW+1:0] shifted;
   logic [VW:0]   diff;

   always_comb begin
      shifted = {prem_i, bit_i};
      diff    = shifted[VW:0] - {1'b0, dvs_i};
      q_o     = (shifted >= {2'b00, dvs_i});
      prem_o  = q_o ? diff : shifted[VW:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: magnitude restoring division, one quotient bit per clock,
// followed by a sign-fix cycle; valid/ready handshakes on both sides.
module seq_divider
   import div_pkg::*;
#(
   parameter int DW = DIV_DW,
   parameter int VW = DIV_VW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [DW-1:0] DIVIDEND,
   input  logic [VW-1:0] DIVISOR,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [DW-1:0] QUOT,
   output logic [VW-1:0] REM,
   output logic          DIV0,
   output logic          OVF
);

   localparam int CW = div_cnt_w(DW);

   div_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] quo_sh_q, quo_sh_d;
   logic [VW:0]   prem_q, prem_d;
   logic [VW-1:0] dvs_mag_q, dvs_mag_d;
   logic [VW-1:0] dvd_lo_q, dvd_lo_d;
   logic          neg_a_q, neg_a_d;
   logic          neg_b_q, neg_b_d;
   logic          z_flag_q, z_flag_d;
   logic          o_flag_q, o_flag_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          div0_q, div0_d;
   logic          ovf_q, ovf_d;

   logic [VW:0]   step_prem;
   logic          step_q;

   div_step #(.VW(VW)) u_step (
      .prem_i (prem_q),
      .bit_i  (quo_sh_q[DW-1]),
      .dvs_i  (dvs_mag_q),
      .prem_o (step_prem),
      .q_o    (step_q)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_sh_d  = quo_sh_q;
      prem_d    = prem_q;
      dvs_mag_d = dvs_mag_q;
      dvd_lo_d  = dvd_lo_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      z_flag_d  = z_flag_q;
      o_flag_d  = o_flag_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               neg_a_d   = DIVIDEND[DW-1];
               neg_b_d   = DIVISOR[VW-1];
               quo_sh_d  = DIVIDEND[DW-1] ? -DIVIDEND : DIVIDEND;
               dvs_mag_d = DIVISOR[VW-1] ? -DIVISOR : DIVISOR;
               dvd_lo_d  = DIVIDEND[VW-1:0];
               z_flag_d  = (DIVISOR == '0);
               o_flag_d  = (DIVIDEND == {1'b1, {(DW-1){1'b0}}}) && (DIVISOR == '1);
               prem_d    = '0;
               cnt_d     = '0;
               state_d   = ITER;
            end
         end
         ITER: begin
            prem_d   = step_prem;
            quo_sh_d = {quo_sh_q[DW-2:0], step_q};
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) state_d = FIX;
         end
         FIX: begin
            if (z_flag_q) begin
               quot_d = '1;
               rem_d  = dvd_lo_q;
               div0_d = 1'b1;
               ovf_d  = 1'b0;
            end else begin
               // Truncating signs; the -2^(DW-1)/-1 magnitude wraps to itself here.
               quot_d = (neg_a_q ^ neg_b_q) ? -quo_sh_q : quo_sh_q;
               rem_d  = neg_a_q ? -prem_q[VW-1:0] : prem_q[VW-1:0];
               div0_d = 1'b0;
               ovf_d  = o_flag_q;
            end
            state_d = DONE;
         end
         DONE: begin
            if (OUT_READY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         quo_sh_q  <= '0;
         prem_q    <= '0;
         dvs_mag_q <= '0;
         dvd_lo_q  <= '0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         z_flag_q  <= 1'b0;
         o_flag_q  <= 1'b0;
         quot_q    <= '0;
         rem_q     <= '0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_sh_q  <= quo_sh_d;
         prem_q    <= prem_d;
         dvs_mag_q <= dvs_mag_d;
         dvd_lo_q  <= dvd_lo_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         z_flag_q  <= z_flag_d;
         o_flag_q  <= o_flag_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         div0_q    <= div0_d;
         ovf_q     <= ovf_d;
      end
   end

   assign IN_READY  = (state_q == IDLE);
   assign OUT_VALID = (state_q == DONE);
   assign QUOT      = quot_q;
   assign REM       = rem_q;
   assign DIV0      = div0_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, mid-operation reset,
// and every operand pair with random handshake gaps against an integer-division model.
module tb_seq_divider;

   localparam int DW = 5;
   localparam int VW = 3;

   logic          CLK;
   logic          RST;
   logic          IN_VALID;
   logic          IN_READY;
   logic [DW-1:0] DIVIDEND;
   logic [VW-1:0] DIVISOR;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [DW-1:0] QUOT;
   logic [VW-1:0] REM;
   logic          DIV0;
   logic          OVF;

   int n_cmp = 0;
   int n_err = 0;

   seq_divider #(.DW(DW), .VW(VW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .DIVIDEND  (DIVIDEND),
      .DIVISOR   (DIVISOR),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .QUOT      (QUOT),
      .REM       (REM),
      .DIV0      (DIV0),
      .OVF       (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Truncating signed division with the divide-by-zero and overflow rules.
   function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                 output logic [DW-1:0] q, output logic [VW-1:0] r,
                                 output logic d0, output logic ov);
      int ai;
      int bi;
      ai = int'($signed(a));
      bi = int'($signed(b));
      if (bi == 0) begin
         q = '1; r = a[VW-1:0]; d0 = 1'b1; ov = 1'b0;
      end else if (ai == -(1 << (DW - 1)) && bi == -1) begin
         q = DW'(ai / bi); r = '0; d0 = 1'b0; ov = 1'b1;
      end else begin
         q = DW'(ai / bi); r = VW'(ai % bi); d0 = 1'b0; ov = 1'b0;
      end
   endfunction

   task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input int in_gap, input int out_gap, input bit rand_rdy);
      logic [DW-1:0] eq;
      logic [VW-1:0] er;
      logic          ed;
      logic          eo;
      int            n;
      model(a, b, eq, er, ed, eo);
      repeat (in_gap) begin
         IN_VALID = 1'b0;
         DIVIDEND = DW'($urandom);
         DIVISOR  = VW'($urandom);
         @(posedge CLK); #1;
      end
      IN_VALID = 1'b1;
      DIVIDEND = a;
      DIVISOR  = b;
      n = 0;
      while (IN_READY !== 1'b1 && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      check("accept_ready", IN_READY, 1);
      @(posedge CLK); #1;
      IN_VALID = 1'($urandom_range(0, 1));
      DIVIDEND = DW'($urandom);
      DIVISOR  = VW'($urandom);
      check("busy_not_ready", IN_READY, 0);
      n = 0;
      while (OUT_VALID !== 1'b1 && n < 20) begin
         if (rand_rdy) OUT_READY = 1'($urandom_range(0, 1));
         @(posedge CLK); #1;
         n++;
      end
      OUT_READY = 1'b0;
      check("latency", n, DW + 1);
      check("quot", QUOT, eq);
      check("rem", REM, er);
      check("div0", DIV0, ed);
      check("ovf", OVF, eo);
      repeat (out_gap) begin
         IN_VALID = 1'b1;
         DIVIDEND = DW'($urandom);
         DIVISOR  = VW'($urandom);
         @(posedge CLK); #1;
         check("hold_valid", OUT_VALID, 1);
         check("hold_in_ready", IN_READY, 0);
         check("hold_quot", QUOT, eq);
         check("hold_rem", REM, er);
         check("hold_flags", {DIV0, OVF}, {ed, eo});
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      check("handoff_valid", OUT_VALID, 0);
      check("handoff_ready", IN_READY, 1);
   endtask

   initial begin
      RST       = 1'b1;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b0;
      DIVIDEND  = '0;
      DIVISOR   = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_in_ready", IN_READY, 1);
      check("rst_out_valid", OUT_VALID, 0);
      check("rst_quot", QUOT, 0);
      check("rst_rem", REM, 0);
      check("rst_flags", {DIV0, OVF}, 2'b00);
      RST = 1'b0;

      // Directed cases: 13/3, -13/3, 13/-4, -16/-1, 7/0.
      run_op(5'd13, 3'd3, 1, 0, 1'b0);
      run_op(5'b10011, 3'd3, 0, 0, 1'b0);
      run_op(5'd13, 3'b100, 0, 0, 1'b0);
      run_op(5'b10000, 3'b111, 0, 0, 1'b0);
      run_op(5'd7, 3'd0, 0, 0, 1'b0);

      // Backpressure for 3 cycles with operands offered, then an immediate next accept.
      run_op(5'd13, 3'd3, 0, 3, 1'b0);
      run_op(5'd5, 3'd1, 0, 0, 1'b0);

      // Reset during the third ITER cycle of 13/3.
      run_op(5'd7, 3'd0, 0, 0, 1'b0);
      IN_VALID = 1'b1;
      DIVIDEND = 5'd13;
      DIVISOR  = 3'd3;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      check("midrst_out_valid", OUT_VALID, 0);
      check("midrst_in_ready", IN_READY, 1);
      check("midrst_quot", QUOT, 0);
      check("midrst_rem", REM, 0);
      check("midrst_flags", {DIV0, OVF}, 2'b00);
      @(posedge CLK); #1;
      RST = 1'b0;
      run_op(5'd10, 3'b110, 0, 0, 1'b0);

      // Every operand pair with random handshake gaps.
      for (int i = 0; i < (1 << (DW + VW)); i++) begin
         logic [DW+VW-1:0] pair;
         pair = (DW + VW)'(i);
         run_op(pair[DW+VW-1:VW], pair[VW-1:0], $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
